// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared constants and entry layout for the IF/ID pipeline boundary
package rv_pipe_pkg;
  localparam int RV_XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  typedef struct packed {
    logic               misaligned;
    logic [RV_XLEN-1:0] pc;
    logic [31:0]        instr;
  } if_id_entry_t;
endpackage

// File: rtl/if_id_fifo_mem.sv
// if_id_fifo_mem: DEPTH-entry register array, one write port, one asynchronous read port
// ports: clk_i clock; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o combinational read port
module if_id_fifo_mem #(
  parameter int W     = 65,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/if_id_skid_buffer.sv
// if_id_skid_buffer: FIFO between fetch and decode with valid/ready handshakes and redirect flush
// ports: Clk/Reset; Fetch_* request side with Fetch_Ready back-pressure; Redirect flush;
//        Decode_* head entry with Decode_Ready consume; Occupancy entry count
module if_id_skid_buffer
  import rv_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Fetch_Valid,
  input  logic [XLEN-1:0]            Fetch_Pc,
  input  logic [31:0]                Fetch_Instruction,
  output logic                       Fetch_Ready,
  input  logic                       Redirect,
  output logic                       Decode_Valid,
  output logic [XLEN-1:0]            Decode_Pc,
  output logic [31:0]                Decode_Instruction,
  output logic                       Decode_Misaligned,
  input  logic                       Decode_Ready,
  output logic [$clog2(DEPTH+1)-1:0] Occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = XLEN + 33;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr, rd;
  logic [EW-1:0] head;
  // Ready looks only at registered state so decode never combinationally reaches fetch.
  assign Fetch_Ready  = !Reset && cnt_q != CW'(DEPTH);
  assign Decode_Valid = cnt_q != '0;
  assign wr = Fetch_Valid && Fetch_Ready && !Redirect;
  assign rd = Decode_Valid && Decode_Ready && !Redirect;
  always_comb begin
    wp_d  = Redirect ? '0 : wp_q + PW'(wr);
    rp_d  = Redirect ? '0 : rp_q + PW'(rd);
    cnt_d = Redirect ? '0 : cnt_q + CW'(wr) - CW'(rd);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  if_id_fifo_mem #(.W(EW), .DEPTH(DEPTH)) u_mem (
    .clk_i  (Clk),
    .we_i   (wr),
    .waddr_i(wp_q),
    .wdata_i({Fetch_Pc[1:0] != 2'b00, Fetch_Pc, Fetch_Instruction}),
    .raddr_i(rp_q),
    .rdata_o(head)
  );
  // Stale storage is masked so an empty buffer always presents a clean NOP bubble.
  assign Decode_Misaligned  = Decode_Valid && head[EW-1];
  assign Decode_Pc          = Decode_Valid ? head[EW-2:32] : '0;
  assign Decode_Instruction = Decode_Valid ? head[31:0] : NOP_INSTR;
  assign Occupancy          = cnt_q;
endmodule

// File: tb/tb_if_id_skid_buffer.sv
// tb_if_id_skid_buffer: queue-model check of the IF/ID buffer with directed and random traffic
module tb_if_id_skid_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Fetch_Valid = 1'b0;
  logic [31:0] Fetch_Pc = '0;
  logic [31:0] Fetch_Instruction = '0;
  logic        Fetch_Ready;
  logic        Redirect = 1'b0;
  logic        Decode_Valid;
  logic [31:0] Decode_Pc;
  logic [31:0] Decode_Instruction;
  logic        Decode_Misaligned;
  logic        Decode_Ready = 1'b0;
  logic [1:0]  Occupancy;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic        mis;
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;
  ent_t q[$];

  if_id_skid_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .Fetch_Valid       (Fetch_Valid),
    .Fetch_Pc          (Fetch_Pc),
    .Fetch_Instruction (Fetch_Instruction),
    .Fetch_Ready       (Fetch_Ready),
    .Redirect          (Redirect),
    .Decode_Valid      (Decode_Valid),
    .Decode_Pc         (Decode_Pc),
    .Decode_Instruction(Decode_Instruction),
    .Decode_Misaligned (Decode_Misaligned),
    .Decode_Ready      (Decode_Ready),
    .Occupancy         (Occupancy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    if (q.size() == 0) begin
      chk("valid", Decode_Valid, 0);
      chk("pc", Decode_Pc, 0);
      chk("instr", Decode_Instruction, 32'h00000013);
      chk("misaligned", Decode_Misaligned, 0);
    end else begin
      chk("valid", Decode_Valid, 1);
      chk("pc", Decode_Pc, q[0].pc);
      chk("instr", Decode_Instruction, q[0].ins);
      chk("misaligned", Decode_Misaligned, q[0].mis);
    end
    chk("occupancy", Occupancy, q.size());
    chk("fetch_ready", Fetch_Ready, !Reset && q.size() != DEPTH);
  endtask

  // Drive one cycle's inputs, advance the model across the edge, then check after the edge.
  task automatic cycle(input logic rst, input logic fv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic dr, input logic redir);
    int  n;
    bit  w, r;
    Reset = rst; Fetch_Valid = fv; Fetch_Pc = pc; Fetch_Instruction = ins;
    Decode_Ready = dr; Redirect = redir;
    if (rst || redir) q.delete();
    else begin
      n = q.size();
      w = fv && n < DEPTH;
      r = dr && n > 0;
      if (r) void'(q.pop_front());
      if (w) q.push_back('{pc[1:0] != 2'b00, pc, ins});
    end
    @(posedge Clk); #1;
    compare();
  endtask

  initial begin
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 32'h4, 32'h1, 1, 0);
    // reset then idle
    cycle(0, 0, 0, 0, 0, 0);
    chk("rst_valid", Decode_Valid, 0);
    chk("rst_instr", Decode_Instruction, 32'h00000013);
    chk("rst_pc", Decode_Pc, 0);
    chk("rst_occ", Occupancy, 0);
    chk("rst_ready", Fetch_Ready, 1);
    // streaming with decode always ready
    cycle(0, 1, 32'h0, 32'h00500093, 1, 0);
    chk("s0_pc", Decode_Pc, 0); chk("s0_valid", Decode_Valid, 1); chk("s0_occ", Occupancy, 1);
    cycle(0, 1, 32'h4, 32'h00108113, 1, 0);
    chk("s1_pc", Decode_Pc, 4); chk("s1_instr", Decode_Instruction, 32'h00108113); chk("s1_occ", Occupancy, 1);
    cycle(0, 1, 32'h8, 32'h002081B3, 1, 0);
    chk("s2_pc", Decode_Pc, 8); chk("s2_instr", Decode_Instruction, 32'h002081B3); chk("s2_occ", Occupancy, 1);
    cycle(0, 0, 0, 0, 1, 0);
    chk("s3_valid", Decode_Valid, 0);
    // back-pressure: two accepted, third held off until a slot frees
    cycle(0, 1, 32'h0, 32'h00500093, 0, 0);
    cycle(0, 1, 32'h4, 32'h00108113, 0, 0);
    chk("bp_occ", Occupancy, 2); chk("bp_ready", Fetch_Ready, 0);
    cycle(0, 1, 32'h8, 32'h002081B3, 0, 0);
    chk("bp_hold_occ", Occupancy, 2); chk("bp_head", Decode_Pc, 0);
    cycle(0, 1, 32'h8, 32'h002081B3, 1, 0);
    chk("bp_rd_occ", Occupancy, 1); chk("bp_rd_head", Decode_Pc, 4); chk("bp_rd_ready", Fetch_Ready, 1);
    cycle(0, 1, 32'h8, 32'h002081B3, 1, 0);
    chk("bp_wr_occ", Occupancy, 1); chk("bp_wr_head", Decode_Pc, 8);
    cycle(0, 0, 0, 0, 1, 0);
    // redirect flush drops buffered and presented pairs
    cycle(0, 1, 32'h10, 32'h11, 0, 0);
    cycle(0, 1, 32'h14, 32'h22, 0, 0);
    cycle(0, 1, 32'h18, 32'h33, 1, 1);
    chk("fl_occ", Occupancy, 0); chk("fl_valid", Decode_Valid, 0);
    cycle(0, 1, 32'h40, 32'h44, 0, 0);
    chk("fl_next", Decode_Pc, 32'h40);
    cycle(0, 0, 0, 0, 1, 0);
    // misaligned flag
    cycle(0, 1, 32'h22, 32'h00000013, 0, 0);
    chk("mis_set", Decode_Misaligned, 1); chk("mis_pc", Decode_Pc, 32'h22);
    cycle(0, 1, 32'h24, 32'h00000013, 1, 0);
    chk("mis_clr", Decode_Misaligned, 0); chk("mis_pc2", Decode_Pc, 32'h24);
    cycle(0, 0, 0, 0, 1, 0);
    // steady simultaneous read/write wraps pointers repeatedly
    cycle(0, 1, 32'h100, 32'h1000, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 32'h104 + 4 * i, 32'h1001 + i, 1, 0);
      chk("ss_occ", Occupancy, 1);
      chk("ss_head", Decode_Pc, 32'h104 + 4 * i);
    end
    cycle(0, 0, 0, 0, 1, 0);
    // mid-stream reset
    cycle(0, 1, 32'h200, 32'h5, 0, 0);
    cycle(1, 1, 32'h204, 32'h6, 0, 0);
    chk("mr_occ", Occupancy, 0); chk("mr_ready", Fetch_Ready, 0);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom,
            $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/if_id_skid_buffer.md
Name: if_id_skid_buffer

Overview:
- Receiving end of the fetch interface. Captures each PC/instruction pair the fetch stage produces and holds it in a small FIFO.
- Presents the oldest entry to decode through a valid/ready handshake.
- Drives a ready signal back to fetch so the PC register holds while the buffer is full.
- Discards all buffered and in-flight entries when execute signals a redirect (JAL, JALR or taken branch).

Parameters:
- XLEN, 32, width of the PC.
- DEPTH, 2, number of FIFO entries; must be a power of two, at least 2.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Fetch_Valid  in  1  fetch presents a valid PC/instruction pair this cycle.
- Fetch_Pc  in  XLEN  PC of the presented instruction.
- Fetch_Instruction  in  32  fetched instruction word.
- Fetch_Ready  out  1  buffer accepts the pair this cycle; fetch holds its PC when this is low.
- Redirect  in  1  OR of Is_JAL, Is_JAL_R and Is_Branch_Taken from execute; flushes the buffer.
- Decode_Valid  out  1  head entry is valid.
- Decode_Pc  out  XLEN  PC of the head entry.
- Decode_Instruction  out  32  instruction of the head entry.
- Decode_Misaligned  out  1  head entry was fetched from a PC whose bits [1:0] are not 00.
- Decode_Ready  in  1  decode consumes the head entry this cycle.
- Occupancy  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Storage:
  - DEPTH entries, each holding {misaligned bit, PC, instruction}.
  - Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - A separate count register tracks occupancy, range 0..DEPTH.
- Handshakes:
  - Fetch_Ready = !Reset && (count != DEPTH). It depends only on registered state, never on Decode_Ready, so there is no combinational path from decode to fetch.
  - Write fires when Fetch_Valid && Fetch_Ready && !Redirect. On a write, the misaligned bit stored is (Fetch_Pc[1:0] != 0).
  - Read fires when Decode_Valid && Decode_Ready && !Redirect.
- Latency:
  - A pair written at edge N is visible on the Decode_* outputs after edge N when the buffer was empty. This is one cycle, with no bypass.
  - Decode_* outputs come from registers/storage only.
- Empty buffer: Decode_Valid = 0, Decode_Pc = 0, Decode_Instruction = 32'h00000013 (NOP), Decode_Misaligned = 0.
- Full buffer:
  - Fetch_Ready = 0, even if decode reads in the same cycle.
  - The freed slot becomes available the following cycle.
- Simultaneous read and write when neither empty nor full: both fire, count is unchanged, and both pointers advance.
- Simultaneous read and write when empty: the read cannot fire because Decode_Valid = 0; the write fires.
- Redirect (highest priority after Reset):
  - At the next edge: count = 0, both pointers = 0, and storage contents are don't-care.
  - The pair presented by fetch in the Redirect cycle is dropped.
  - Decode_Ready in the Redirect cycle has no effect.
  - Fetch_Ready is not gated by Redirect; the dropped transfer is simply not stored.
- Reset:
  - At the next edge: count = 0 and pointers = 0.
  - Outputs take the empty values above; Occupancy = 0.
  - Fetch_Ready = 0 while Reset is high.
  - Reset asserted mid-stream discards all entries, identical to a flush.
- Ordering: strict FIFO; every accepted pair is delivered exactly once unless a flush occurs.

Decomposition:
- Shared package rv_pipe_pkg:
  - NOP_INSTR = 32'h00000013
  - typedef if_id_entry_t {logic misaligned; logic [XLEN-1:0] pc; logic [31:0] instr;}
- One sub-module is natural: if_id_fifo_mem, a DEPTH-entry register array with one write port and one asynchronous read port.
- Pointer, count and flush logic stay in the top level.

Test Plan:
- Reset, then idle -> Decode_Valid=0, Decode_Instruction=0x00000013, Decode_Pc=0, Occupancy=0, and Fetch_Ready=1 in the first cycle after Reset deasserts.
- Stream pairs {0x0,0x00500093}, {0x4,0x00108113}, {0x8,0x002081B3} with Decode_Ready=1 -> identical pairs emerge in order, each one cycle after acceptance; Occupancy never exceeds 1.
- Decode_Ready=0 while 3 pairs are offered -> first 2 are accepted, Fetch_Ready=0 and Occupancy=2. Raise Decode_Ready -> PC 0x0 is delivered first; the third pair (0x8) is accepted one cycle after the first read.
- Buffer holds 0x10 and 0x14; Redirect=1 with fetch offering 0x18 -> next cycle Occupancy=0 and Decode_Valid=0; a subsequent pair at 0x40 is delivered first.
- Fetch_Pc=0x22 with instruction 0x00000013 -> delivered with Decode_Misaligned=1; next pair 0x24 has Decode_Misaligned=0.
- Occupancy=1 with a simultaneous write and read for 20 cycles -> Occupancy stays 1, no pair is lost or duplicated, and pointers wrap correctly through 0 at least 5 times.
